router_fsm: RTL and testbench
=============================

// Module: router_fsm
// PURPOSE
//  Control FSM of the 1x3 router; sits upstream of router_reg and drives its stage strobes
//  (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) plus the FIFO write enable.
//  It latches the 2-bit destination from the header and waits for that FIFO to drain.
//  It stalls the source via busy, and sequences the payload, full and parity phases.
// PARAMETERS
//  NUM_PORTS  3  output FIFOs addressed; header addr >= NUM_PORTS is invalid
//  ADDR_W     2  width of address field datain[ADDR_W-1:0]
// PORTS
//  clk               in   1          rising-edge clock
//  resetn            in   1          async active-low reset
//  packet_valid      in   1          source byte valid; falls after last payload byte (parity byte follows)
//  datain            in   ADDR_W     address field of the header byte
//  fifo_full         in   1          full flag of the currently selected FIFO
//  fifo_empty        in   NUM_PORTS  per-FIFO empty flags
//  soft_reset        in   NUM_PORTS  per-FIFO read-timeout soft resets
//  parity_done       in   1          from router_reg: parity byte captured
//  low_packet_valid  in   1          from router_reg: packet_valid fell while FIFO full
//  write_enb_reg     out  1          write strobe to the selected FIFO
//  detect_add / lfd_state / ld_state / laf_state / full_state / rst_int_reg  out  1  one-hot state decodes
//  busy              out  1          source must hold current byte
// BEHAVIOUR
//  Reset: state=DA, addr_q=0; detect_add=1, all other outputs 0. Moore outputs, decoded from state only.
//  Decodes: detect_add=DA, lfd_state=LFD, ld_state=LD, laf_state=LAF, full_state=FFS, rst_int_reg=CPE.
//  write_enb_reg = LD|LAF|LP.  busy = LFD|FFS|LAF|LP|CPE|WTE; busy=0 in DA and LD.
//  Transitions, evaluated each posedge:
//   DA : packet_valid & addr valid -> LFD if fifo_empty[addr], else WTE; addr_q<=datain in that cycle.
//   WTE: fifo_empty[addr_q] -> LFD; else hold.
//   LFD: -> LD unconditionally, 1 cycle; router_reg writes the header here.
//   LD : fifo_full -> FFS; else !packet_valid -> LP; else hold. fifo_full has priority.
//   FFS: !fifo_full -> LAF; else hold.
//   LAF: parity_done -> DA; else low_packet_valid -> LP; else -> LD.
//   LP : -> CPE, 1 cycle.
//   CPE: fifo_full -> FFS; else -> DA.
//  soft_reset[addr_q]=1 in any state except DA forces next state to DA.
//   This beats every other condition and does not affect the address latch.
//  soft_reset for a non-selected port is ignored. packet_valid=0 in DA: hold, no addr capture.
//  Async reset mid-packet: immediate return to DA and reset outputs; the partial packet is abandoned.
// CONFIGURATION
//  ROUTER_FSM_DROP_INVALID_EN defined:
//   DA with packet_valid and addr==2'b11 -> DROP state.
//   DROP: all outputs 0 (busy=0, no writes); on !packet_valid -> DA. The whole packet, incl. parity, is discarded.
//  Undefined: addr==2'b11 header holds DA. Following bytes are re-decoded as headers; no DROP state is built.
// STRUCTURE
//  router_pkg:
//   - state encodings DA,LFD,LD,FFS,LAF,LP,CPE,WTE,DROP (4-bit localparams)
//   - ADDR_INVALID=2'b11
//   - shared by router_reg/router_fifo benches
//  Sub-module router_addr_sel: captures addr_q in DA and muxes fifo_empty/soft_reset to 1-bit sel_empty/sel_soft_reset.
//  router_fsm holds only next-state logic, state register and output decode.
// TESTING
//  1 reset, then addr=2'b01 header with fifo_empty=3'b111, 8 payload, parity, no full.
//    -> DA,LFD,LD x8,LP,CPE,DA; write_enb_reg high 9 cycles; busy low during LD.
//  2 header addr=2'b10 with fifo_empty[2]=0 for 5 cycles.
//    -> WTE for 5 cycles, busy=1, no write; LFD cycle after fifo_empty[2] rises.
//  3 fifo_full=1 on payload byte 4 for 3 cycles.
//    -> LD->FFS (3 cycles, write_enb=0), LAF, LD; byte 4 re-written in LAF, total payload writes still 8.
//  4 fifo_full during the last byte, packet_valid falls meanwhile, low_packet_valid=1.
//    -> FFS,LAF,LP,CPE,DA; rst_int_reg pulses 1 cycle.
//  5 soft_reset[1]=1 mid-LD for addr 1 -> DA next cycle, detect_add=1; soft_reset[0] pulse in same packet -> ignored.
//  6 addr=2'b11 header, 4 bytes.
//    -> with ROUTER_FSM_DROP_INVALID_EN: DROP until packet_valid=0, write_enb_reg never 1.
//    -> without it: remains DA.
//  Plus: resetn low mid-LD -> outputs at reset values within the same cycle, no clock edge needed.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: port geometry, FSM state codes, reserved address.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;

  localparam logic [3:0] DA   = 4'd0;
  localparam logic [3:0] LFD  = 4'd1;
  localparam logic [3:0] LD   = 4'd2;
  localparam logic [3:0] FFS  = 4'd3;
  localparam logic [3:0] LAF  = 4'd4;
  localparam logic [3:0] LP   = 4'd5;
  localparam logic [3:0] CPE  = 4'd6;
  localparam logic [3:0] WTE  = 4'd7;
  localparam logic [3:0] DROP = 4'd8;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_addr_sel.sv
// Destination latch for the router FSM; selects the empty/soft-reset flags of the
// incoming header address and of the latched destination.
module router_addr_sel
  import router_pkg::*;
#(
  parameter int P_NUM_PORTS = NUM_PORTS,
  parameter int P_ADDR_W    = ADDR_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   capture,
  input  logic [P_ADDR_W-1:0]    datain,
  input  logic [P_NUM_PORTS-1:0] fifo_empty,
  input  logic [P_NUM_PORTS-1:0] soft_reset,
  output logic                   addr_valid,
  output logic                   in_empty,
  output logic                   sel_empty,
  output logic                   sel_soft_reset
);

  logic [P_ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      addr_q <= '0;
    else if (capture)
      addr_q <= datain;
  end

  assign addr_valid = (int'(datain) < P_NUM_PORTS);

  // Loop-based mux keeps out-of-range addresses from indexing past the flag vectors.
  always_comb begin
    in_empty       = 1'b0;
    sel_empty      = 1'b0;
    sel_soft_reset = 1'b0;
    for (int i = 0; i < P_NUM_PORTS; i++) begin
      if (datain == P_ADDR_W'(i))
        in_empty = fifo_empty[i];
      if (addr_q == P_ADDR_W'(i)) begin
        sel_empty      = fifo_empty[i];
        sel_soft_reset = soft_reset[i];
      end
    end
  end

endmodule

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: header decode, FIFO wait, payload/full/parity sequencing.
// Optional ROUTER_FSM_DROP_INVALID_EN adds a DROP state that swallows packets to the reserved address.
//
//  state | meaning
//  DA    | detect address: idle, waiting for a header byte
//  WTE   | wait until the selected FIFO is empty
//  LFD   | load first data: header written by router_reg
//  LD    | load payload bytes
//  FFS   | selected FIFO full, stall the source
//  LAF   | load after full: rewrite the byte held during the stall
//  LP    | load parity byte
//  CPE   | check parity error / internal register reset
//  DROP  | discard a packet addressed to the reserved port
module router_fsm
  import router_pkg::*;
#(
  parameter int P_NUM_PORTS = NUM_PORTS,
  parameter int P_ADDR_W    = ADDR_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   packet_valid,
  input  logic [P_ADDR_W-1:0]    datain,
  input  logic                   fifo_full,
  input  logic [P_NUM_PORTS-1:0] fifo_empty,
  input  logic [P_NUM_PORTS-1:0] soft_reset,
  input  logic                   parity_done,
  input  logic                   low_packet_valid,
  output logic                   write_enb_reg,
  output logic                   detect_add,
  output logic                   lfd_state,
  output logic                   ld_state,
  output logic                   laf_state,
  output logic                   full_state,
  output logic                   rst_int_reg,
  output logic                   busy
);

  logic [3:0] state, next_state;
  logic       addr_valid, in_empty, sel_empty, sel_soft_reset;
  logic       capture;

  assign capture = (state == DA) && packet_valid && addr_valid;

  router_addr_sel #(
    .P_NUM_PORTS(P_NUM_PORTS),
    .P_ADDR_W   (P_ADDR_W)
  ) u_addr_sel (
    .clk           (clk),
    .resetn        (resetn),
    .capture       (capture),
    .datain        (datain),
    .fifo_empty    (fifo_empty),
    .soft_reset    (soft_reset),
    .addr_valid    (addr_valid),
    .in_empty      (in_empty),
    .sel_empty     (sel_empty),
    .sel_soft_reset(sel_soft_reset)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= DA;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      DA: begin
        if (packet_valid && addr_valid)
          next_state = in_empty ? LFD : WTE;
`ifdef ROUTER_FSM_DROP_INVALID_EN
        else if (packet_valid && (datain == ADDR_INVALID))
          next_state = DROP;
`endif
      end
      WTE:  if (sel_empty) next_state = LFD;
      LFD:  next_state = LD;
      LD: begin
        if (fifo_full)
          next_state = FFS;
        else if (!packet_valid)
          next_state = LP;
      end
      FFS:  if (!fifo_full) next_state = LAF;
      LAF: begin
        if (parity_done)
          next_state = DA;
        else if (low_packet_valid)
          next_state = LP;
        else
          next_state = LD;
      end
      LP:   next_state = CPE;
      CPE:  next_state = fifo_full ? FFS : DA;
`ifdef ROUTER_FSM_DROP_INVALID_EN
      DROP: if (!packet_valid) next_state = DA;
`endif
      default: next_state = DA;
    endcase
    // A read timeout on the selected FIFO abandons the packet from any active state.
    if ((state != DA) && sel_soft_reset)
      next_state = DA;
  end

  always_comb begin
    detect_add    = (state == DA);
    lfd_state     = (state == LFD);
    ld_state      = (state == LD);
    laf_state     = (state == LAF);
    full_state    = (state == FFS);
    rst_int_reg   = (state == CPE);
    write_enb_reg = (state == LD) || (state == LAF) || (state == LP);
    busy          = (state == LFD) || (state == FFS) || (state == LAF) ||
                    (state == LP)  || (state == CPE) || (state == WTE);
  end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed packet scenarios plus random inputs,
// all checked every cycle against a packet-phase model.
module tb_router_fsm;

  logic       clk, resetn;
  logic       packet_valid, fifo_full, parity_done, low_packet_valid;
  logic [1:0] datain;
  logic [2:0] fifo_empty, soft_reset;
  logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, busy;

  router_fsm dut (
    .clk             (clk),
    .resetn          (resetn),
    .packet_valid    (packet_valid),
    .datain          (datain),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .soft_reset      (soft_reset),
    .parity_done     (parity_done),
    .low_packet_valid(low_packet_valid),
    .write_enb_reg   (write_enb_reg),
    .detect_add      (detect_add),
    .lfd_state       (lfd_state),
    .ld_state        (ld_state),
    .laf_state       (laf_state),
    .full_state      (full_state),
    .rst_int_reg     (rst_int_reg),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packet-phase model; output vector order {detect,lfd,ld,laf,full,rst_int,write,busy}.
  typedef enum {M_IDLE, M_WAIT, M_HDR, M_LOAD, M_STALL, M_AFTER, M_PAR, M_CHK, M_DROP} mph_t;
  mph_t       m_ph;
  logic [1:0] m_addr;

  function automatic logic [7:0] m_out(mph_t p);
    case (p)
      M_IDLE:  return 8'b1000_0000;
      M_HDR:   return 8'b0100_0001;
      M_LOAD:  return 8'b0010_0010;
      M_STALL: return 8'b0000_1001;
      M_AFTER: return 8'b0001_0011;
      M_PAR:   return 8'b0000_0011;
      M_CHK:   return 8'b0000_0101;
      M_WAIT:  return 8'b0000_0001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ph   <= M_IDLE;
      m_addr <= 2'd0;
    end else if (m_ph != M_IDLE && soft_reset[m_addr]) begin
      m_ph <= M_IDLE;
    end else begin
      case (m_ph)
        M_IDLE: begin
          if (packet_valid && datain < 2'd3) begin
            m_addr <= datain;
            m_ph   <= fifo_empty[datain] ? M_HDR : M_WAIT;
          end
`ifdef ROUTER_FSM_DROP_INVALID_EN
          else if (packet_valid && datain == 2'd3) m_ph <= M_DROP;
`endif
        end
        M_WAIT:  if (fifo_empty[m_addr]) m_ph <= M_HDR;
        M_HDR:   m_ph <= M_LOAD;
        M_LOAD:  m_ph <= fifo_full ? M_STALL : (!packet_valid ? M_PAR : M_LOAD);
        M_STALL: if (!fifo_full) m_ph <= M_AFTER;
        M_AFTER: m_ph <= parity_done ? M_IDLE : (low_packet_valid ? M_PAR : M_LOAD);
        M_PAR:   m_ph <= M_CHK;
        M_CHK:   m_ph <= fifo_full ? M_STALL : M_IDLE;
        M_DROP:  if (!packet_valid) m_ph <= M_IDLE;
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  int n_chk, n_fail, cyc;
  int cnt_we, cnt_ld, cnt_rst, cnt_full, cnt_laf, cnt_lfd, cnt_wait;
  logic [7:0] dvec;
  assign dvec = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                 write_enb_reg, busy};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    cnt_we = 0; cnt_ld = 0; cnt_rst = 0; cnt_full = 0; cnt_laf = 0; cnt_lfd = 0; cnt_wait = 0;
  endtask

  // One cycle: drive inputs, compare against the model mid-cycle, advance past the edge.
  task automatic step(input logic pv, input logic [1:0] din, input logic [2:0] fe,
                      input logic ff, input logic [2:0] sr, input logic pd, input logic lpv);
    packet_valid = pv; datain = din; fifo_empty = fe; fifo_full = ff;
    soft_reset = sr; parity_done = pd; low_packet_valid = lpv;
    @(negedge clk);
    n_chk++;
    if (dvec !== m_out(m_ph)) begin
      n_fail++;
      $display("FAIL model cyc %0d: got %b expected %b", cyc, dvec, m_out(m_ph));
    end
    cnt_we   += int'(write_enb_reg);
    cnt_ld   += int'(ld_state);
    cnt_rst  += int'(rst_int_reg);
    cnt_full += int'(full_state);
    cnt_laf  += int'(laf_state);
    cnt_lfd  += int'(lfd_state);
    cnt_wait += int'(busy && !write_enb_reg && !lfd_state && !full_state && !rst_int_reg);
    cyc++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    clr();
    resetn = 1'b0; packet_valid = 0; datain = 0; fifo_empty = 3'b111;
    fifo_full = 0; soft_reset = 0; parity_done = 0; low_packet_valid = 0;
    #3;
    chk("reset_outputs", 32'(dvec), 32'h80);
    #5 resetn = 1'b1;
    @(posedge clk); #2;

    // 1: addr 1, 8 payload cycles, parity
    clr();
    step(1, 2'd1, 3'b111, 0, 0, 0, 0);
    step(1, 2'd1, 3'b111, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    step(0, 2'd0, 3'b111, 0, 0, 0, 0);
    step(0, 2'd0, 3'b111, 0, 0, 0, 0);
    step(0, 2'd0, 3'b111, 0, 0, 0, 0);
    step(0, 2'd0, 3'b111, 0, 0, 0, 0);
    chk("s1_ld_cycles", 32'(cnt_ld), 32'd8);
    chk("s1_writes", 32'(cnt_we), 32'd9);
    chk("s1_rst_int", 32'(cnt_rst), 32'd1);
    chk("s1_back_da", 32'(detect_add), 32'd1);

    // 2: addr 2 waits for its FIFO to drain
    clr();
    for (int i = 0; i < 5; i++) step(1, 2'd2, 3'b011, 0, 0, 0, 0);
    step(1, 2'd2, 3'b111, 0, 0, 0, 0);
    chk("s2_wait_cycles", 32'(cnt_wait), 32'd5);
    chk("s2_no_write", 32'(cnt_we), 32'd0);
    chk("s2_lfd_now", 32'(lfd_state), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 2'd0, 3'b111, 0, 0, 0, 0);

    // 3: FIFO full on payload byte 4 for 3 cycles
    clr();
    step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    step(1, 2'd0, 3'b111, 1, 0, 0, 0);
    step(1, 2'd0, 3'b111, 1, 0, 0, 0);
    step(1, 2'd0, 3'b111, 1, 0, 0, 0);
    step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    chk("s3_full_cycles", 32'(cnt_full), 32'd3);
    chk("s3_laf_cycles", 32'(cnt_laf), 32'd1);
    chk("s3_back_in_ld", 32'(ld_state), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 2'd0, 3'b111, 0, 0, 0, 0);

    // 4: full during the last byte, packet_valid falls, low_packet_valid set
    clr();
    step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    step(1, 2'd0, 3'b111, 1, 0, 0, 0);
    step(0, 2'd0, 3'b111, 0, 0, 0, 1);
    step(0, 2'd0, 3'b111, 0, 0, 0, 1);
    chk("s4_in_lp", 32'(dvec), 32'h03);
    step(0, 2'd0, 3'b111, 0, 0, 0, 0);
    step(0, 2'd0, 3'b111, 0, 0, 0, 0);
    chk("s4_rst_pulse", 32'(cnt_rst), 32'd1);
    chk("s4_back_da", 32'(detect_add), 32'd1);

    // 5: soft reset on the other port ignored, on the selected port aborts
    step(1, 2'd1, 3'b111, 0, 0, 0, 0);
    step(1, 2'd1, 3'b111, 0, 0, 0, 0);
    step(1, 2'd0, 3'b111, 0, 3'b001, 0, 0);
    chk("s5_sr0_ignored", 32'(ld_state), 32'd1);
    step(1, 2'd0, 3'b111, 0, 3'b010, 0, 0);
    chk("s5_sr1_abort", 32'(dvec), 32'h80);
    step(0, 2'd0, 3'b111, 0, 0, 0, 0);

    // 6: reserved address
    clr();
    for (int i = 0; i < 4; i++) step(1, 2'd3, 3'b111, 0, 0, 0, 0);
`ifdef ROUTER_FSM_DROP_INVALID_EN
    chk("s6_drop_outputs", 32'(dvec), 32'h00);
`else
    chk("s6_hold_da", 32'(dvec), 32'h80);
`endif
    step(0, 2'd0, 3'b111, 0, 0, 0, 0);
    chk("s6_no_write", 32'(cnt_we), 32'd0);
    step(0, 2'd0, 3'b111, 0, 0, 0, 0);

    // async reset mid-LD
    step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    step(1, 2'd0, 3'b111, 0, 0, 0, 0);
    chk("ar_in_ld", 32'(ld_state), 32'd1);
    resetn = 1'b0;
    #1;
    chk("ar_outputs", 32'(dvec), 32'h80);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #2;
    step(0, 2'd0, 3'b111, 0, 0, 0, 0);

    // random inputs
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] fe, sr;
      fe = 3'b000;
      sr = 3'b000;
      for (int b = 0; b < 3; b++) begin
        fe[b] = ($urandom_range(0, 9) < 7);
        sr[b] = ($urandom_range(0, 99) < 3);
      end
      step(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)), fe,
           ($urandom_range(0, 99) < 15), sr,
           ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
